// File: rtl/proc_1_cpu_debug_mon_access.sv
// proc_1_cpu_debug_mon_access
// System-clock debug monitor-access stage. Executes JTAG monitor commands
// (set address / read / write) against a 32-bit on-chip debug RAM and shares
// that RAM with the CPU debug slave port (Avalon-MM with waitrequest).
//
// Ports:
//   clk, reset_n               system clock, asynchronous active-low reset
//   jdo                        JTAG command payload (stable while strobes high)
//   take_action_ocimem_a       set MonAReg from jdo[33:26]; read if jdo[25]
//   take_no_action_ocimem_a    read word at MonAReg, then MonAReg+1
//   take_action_ocimem_b       write jdo[34:3] at MonAReg, then MonAReg+1
//   MonDReg, MonAReg           monitor data / word-address registers
//   monitor_ready/_error       completion / fault of last JTAG command
//   address..debugaccess       CPU Avalon-MM request
//   readdata, waitrequest      CPU Avalon-MM response
module proc_1_cpu_debug_mon_access #(
  parameter int unsigned     AW      = 8,
  parameter logic [AW-1:0]   RO_BASE = 8'hC0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  output logic [31:0]   MonDReg,
  output logic [AW-1:0] MonAReg,
  output logic          monitor_ready,
  output logic          monitor_error,
  input  logic [AW-1:0] address,
  input  logic          read,
  input  logic          write,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  input  logic          debugaccess,
  output logic [31:0]   readdata,
  output logic          waitrequest
);

  localparam int unsigned   DEPTH = 1 << AW;
  localparam logic [AW-1:0] A_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_J_READ = 2'd1,
    S_C_READ = 2'd2,
    S_C_ACK  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_SET        = 2'd0,
    CMD_SET_READ   = 2'd1,
    CMD_NOACT_READ = 2'd2,
    CMD_WRITE      = 2'd3
  } cmd_e;

  state_e        state_q, state_d;
  logic          pend_valid_q, pend_valid_d;
  cmd_e          pend_cmd_q, pend_cmd_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic          jread_inc_q, jread_inc_d;
  logic [AW-1:0] mon_a_q, mon_a_d;
  logic [31:0]   mon_d_q, mon_d_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          waitreq_q, waitreq_d;

  logic          strobe_s, busy_s, accept_s;
  logic [AW-1:0] ram_addr_s;
  logic          ram_we_s;
  logic [3:0]    ram_be_s;
  logic [31:0]   ram_wdata_s;
  logic [31:0]   ram_rdata_q;
  logic [31:0]   mem [0:DEPTH-1];

  // Next-state, RAM port control and JTAG command acceptance
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_cmd_d   = pend_cmd_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    jread_inc_d  = jread_inc_q;
    mon_a_d      = mon_a_q;
    mon_d_d      = mon_d_q;
    ready_d      = ready_q;
    error_d      = error_q;
    readdata_d   = readdata_q;
    ram_addr_s   = mon_a_q;
    ram_we_s     = 1'b0;
    ram_be_s     = 4'h0;
    ram_wdata_s  = 32'h0;

    // A command counts as outstanding until monitor_ready is raised, so a
    // JTAG read in flight (J_READ) also blocks new strobes.
    strobe_s = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    busy_s   = pend_valid_q | (state_q == S_J_READ);
    accept_s = strobe_s & ~busy_s;

    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          // JTAG always wins over the CPU, so it cannot be starved
          pend_valid_d = 1'b0;
          case (pend_cmd_q)
            CMD_SET: begin
              mon_a_d = pend_addr_q;
              ready_d = 1'b1;
            end
            CMD_SET_READ: begin
              mon_a_d     = pend_addr_q;
              ram_addr_s  = pend_addr_q;
              jread_inc_d = 1'b0;
              state_d     = S_J_READ;
            end
            CMD_NOACT_READ: begin
              jread_inc_d = 1'b1;
              state_d     = S_J_READ;
            end
            CMD_WRITE: begin
              mon_d_d = pend_data_q;
              mon_a_d = mon_a_q + A_ONE;
              ready_d = 1'b1;
              if (mon_a_q < RO_BASE) begin
                ram_we_s    = 1'b1;
                ram_be_s    = 4'hF;
                ram_wdata_s = pend_data_q;
              end else begin
                error_d = 1'b1;
              end
            end
            default: begin
              pend_valid_d = 1'b0;
            end
          endcase
        end else if (read) begin
          ram_addr_s = address;
          state_d    = S_C_READ;
        end else if (write) begin
          ram_addr_s = address;
          state_d    = S_C_ACK;
          // Writes without debug permission or into the protected region
          // are acknowledged but dropped
          if (debugaccess && (address < RO_BASE)) begin
            ram_we_s    = 1'b1;
            ram_be_s    = byteenable;
            ram_wdata_s = writedata;
          end else begin
            ram_we_s = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_J_READ: begin
        mon_d_d = ram_rdata_q;
        ready_d = 1'b1;
        state_d = S_IDLE;
        if (jread_inc_q) begin
          mon_a_d = mon_a_q + A_ONE;
        end else begin
          mon_a_d = mon_a_q;
        end
      end
      S_C_READ: begin
        readdata_d = ram_rdata_q;
        state_d    = S_IDLE;
      end
      S_C_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Acceptance never coincides with a completion (completion only happens
    // while busy), so overriding ready/error here is safe.
    if (accept_s) begin
      ready_d      = 1'b0;
      error_d      = 1'b0;
      pend_valid_d = 1'b1;
      pend_addr_d  = AW'(jdo[33:26]);
      pend_data_d  = jdo[34:3];
      if (take_action_ocimem_b) begin
        pend_cmd_d = CMD_WRITE;
      end else if (take_no_action_ocimem_a) begin
        pend_cmd_d = CMD_NOACT_READ;
      end else if (jdo[25]) begin
        pend_cmd_d = CMD_SET_READ;
      end else begin
        pend_cmd_d = CMD_SET;
      end
    end else if (strobe_s) begin
      error_d = 1'b1;
    end else begin
      pend_cmd_d = pend_cmd_q;
    end

    waitreq_d = ~((state_d == S_C_READ) | (state_d == S_C_ACK));
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= CMD_SET;
      pend_addr_q  <= '0;
      pend_data_q  <= 32'h0;
      jread_inc_q  <= 1'b0;
      mon_a_q      <= '0;
      mon_d_q      <= 32'h0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
      readdata_q   <= 32'h0;
      waitreq_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_cmd_q   <= pend_cmd_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      jread_inc_q  <= jread_inc_d;
      mon_a_q      <= mon_a_d;
      mon_d_q      <= mon_d_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
      readdata_q   <= readdata_d;
      waitreq_q    <= waitreq_d;
    end
  end

  // Debug RAM: single port, byte-lane writes, registered read data, never reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be_s[i]) begin
          mem[ram_addr_s][8*i +: 8] <= ram_wdata_s[8*i +: 8];
        end
      end
    end
    ram_rdata_q <= mem[ram_addr_s];
  end

  // readdata must be valid in the C_READ cycle itself, so it bypasses the
  // holding register while the RAM output is being returned.
  assign readdata      = (state_q == S_C_READ) ? ram_rdata_q : readdata_q;
  assign waitrequest   = waitreq_q;
  assign MonDReg       = mon_d_q;
  assign MonAReg       = mon_a_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_proc_1_cpu_debug_mon_access.sv
module tb_proc_1_cpu_debug_mon_access;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [7:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        debugaccess;
  logic [31:0] readdata;
  logic        waitrequest;

  proc_1_cpu_debug_mon_access dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .debugaccess(debugaccess),
    .readdata(readdata), .waitrequest(waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef enum int {OP_CWR, OP_CRD, OP_JSET, OP_JNOACT, OP_JWR} op_e;

  typedef struct {
    op_e         op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        flag;    // debugaccess for CPU writes, read bit for JSET
    logic        chk_d;   // compare MonDReg (JTAG) / readdata (CPU read)
    logic [31:0] exp_d;
    logic [7:0]  exp_a;
    logic        exp_err;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: spec-level view of RAM and monitor registers
  logic [31:0] mem_m [256];
  logic [3:0]  kn_m  [256];
  logic [7:0]  mona_m;
  logic [31:0] mond_m;
  logic [3:0]  mondk_m;
  logic        rdy_m, err_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry: idle, nothing pending. Exit: command complete, FSM idle.
  task automatic jtag_op(input op_e op, input logic [7:0] a, input logic rd, input logic [31:0] d);
    int lat;
    jdo = 38'd0;
    lat = 2;
    case (op)
      OP_JSET: begin
        jdo[33:26] = a; jdo[25] = rd; take_action_ocimem_a = 1'b1;
        lat = rd ? 3 : 2;
      end
      OP_JNOACT: begin take_no_action_ocimem_a = 1'b1; lat = 3; end
      default:   begin jdo[34:3] = d; take_action_ocimem_b = 1'b1; lat = 2; end
    endcase
    tick();
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    check("jtag_ready_cleared", 32'(monitor_ready), 32'd0);
    tick();
    if (lat == 3) begin
      check("jtag_ready_not_early", 32'(monitor_ready), 32'd0);
      tick();
    end
    check("jtag_ready_on_time", 32'(monitor_ready), 32'd1);
    rdy_m = 1'b1;
    err_m = 1'b0;
    case (op)
      OP_JSET: begin
        mona_m = a;
        if (rd) begin mond_m = mem_m[a]; mondk_m = kn_m[a]; end
      end
      OP_JNOACT: begin
        mond_m = mem_m[mona_m]; mondk_m = kn_m[mona_m]; mona_m = mona_m + 8'd1;
      end
      default: begin
        mond_m = d; mondk_m = 4'hF;
        if (mona_m < 8'hC0) begin mem_m[mona_m] = d; kn_m[mona_m] = 4'hF; end
        else err_m = 1'b1;
        mona_m = mona_m + 8'd1;
      end
    endcase
  endtask

  // Entry: idle, nothing pending. Exit: FSM idle again.
  task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic dbg, output logic [31:0] rd_o);
    address = a; writedata = d; byteenable = be; debugaccess = dbg;
    read = ~wr; write = wr;
    check("cpu_wait_in_req_cycle", 32'(waitrequest), 32'd1);
    tick();
    check("cpu_wait_drop", 32'(waitrequest), 32'd0);
    rd_o = readdata;
    read = 1'b0; write = 1'b0;
    tick();
    if (wr && dbg && (a < 8'hC0)) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin mem_m[a][8*i +: 8] = d[8*i +: 8]; kn_m[a][i] = 1'b1; end
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_mona"}, 32'(MonAReg), 32'(mona_m));
    check({tag, "_ready"}, 32'(monitor_ready), 32'(rdy_m));
    check({tag, "_error"}, 32'(monitor_error), 32'(err_m));
    check({tag, "_mond"}, MonDReg & bmask(mondk_m), mond_m & bmask(mondk_m));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_waitrequest"}, 32'(waitrequest), 32'd1);
    check({tag, "_mond"}, MonDReg, 32'd0);
    check({tag, "_mona"}, 32'(MonAReg), 32'd0);
    check({tag, "_ready"}, 32'(monitor_ready), 32'd0);
    check({tag, "_error"}, 32'(monitor_error), 32'd0);
    check({tag, "_readdata"}, readdata, 32'd0);
  endtask

  vec_t        tbl [23];
  logic [31:0] rv, c0_before;
  logic [7:0]  ra;
  int          sel;

  initial begin
    tbl[0]  = '{OP_CWR,    8'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0,        8'h00, 1'b0};
    tbl[1]  = '{OP_CWR,    8'h05, 32'h00000000, 4'hF, 1'b1, 1'b0, 32'h0,        8'h00, 1'b0};
    tbl[2]  = '{OP_CWR,    8'h05, 32'hAABBCCDD, 4'h3, 1'b1, 1'b0, 32'h0,        8'h00, 1'b0};
    tbl[3]  = '{OP_CRD,    8'h05, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0000CCDD, 8'h00, 1'b0};
    tbl[4]  = '{OP_CWR,    8'h05, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0,        8'h00, 1'b0};
    tbl[5]  = '{OP_CRD,    8'h05, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0000CCDD, 8'h00, 1'b0};
    tbl[6]  = '{OP_CWR,    8'hC0, 32'h5A5A5A5A, 4'hF, 1'b1, 1'b0, 32'h0,        8'h00, 1'b0};
    tbl[7]  = '{OP_CWR,    8'hBE, 32'h77777777, 4'hF, 1'b1, 1'b0, 32'h0,        8'h00, 1'b0};
    tbl[8]  = '{OP_JSET,   8'h10, 32'h0,        4'h0, 1'b1, 1'b1, 32'hDEADBEEF, 8'h10, 1'b0};
    tbl[9]  = '{OP_JSET,   8'hBE, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 8'hBE, 1'b0};
    tbl[10] = '{OP_JWR,    8'h00, 32'h1,        4'h0, 1'b0, 1'b1, 32'h1,        8'hBF, 1'b0};
    tbl[11] = '{OP_JWR,    8'h00, 32'h2,        4'h0, 1'b0, 1'b1, 32'h2,        8'hC0, 1'b0};
    tbl[12] = '{OP_JWR,    8'h00, 32'h3,        4'h0, 1'b0, 1'b1, 32'h3,        8'hC1, 1'b1};
    tbl[13] = '{OP_CRD,    8'hBE, 32'h0,        4'hF, 1'b0, 1'b1, 32'h1,        8'h00, 1'b0};
    tbl[14] = '{OP_CRD,    8'hBF, 32'h0,        4'hF, 1'b0, 1'b1, 32'h2,        8'h00, 1'b0};
    tbl[15] = '{OP_JSET,   8'hFF, 32'h0,        4'h0, 1'b0, 1'b1, 32'h3,        8'hFF, 1'b0};
    tbl[16] = '{OP_JNOACT, 8'h00, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        8'h00, 1'b0};
    tbl[17] = '{OP_JSET,   8'h20, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        8'h20, 1'b0};
    tbl[18] = '{OP_JWR,    8'h00, 32'hCAFEF00D, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D, 8'h21, 1'b0};
    tbl[19] = '{OP_CRD,    8'h20, 32'h0,        4'hF, 1'b0, 1'b1, 32'hCAFEF00D, 8'h00, 1'b0};
    tbl[20] = '{OP_JSET,   8'h20, 32'h0,        4'h0, 1'b0, 1'b1, 32'hCAFEF00D, 8'h20, 1'b0};
    tbl[21] = '{OP_JNOACT, 8'h00, 32'h0,        4'h0, 1'b0, 1'b1, 32'hCAFEF00D, 8'h21, 1'b0};
    tbl[22] = '{OP_JSET,   8'h05, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0000CCDD, 8'h05, 1'b0};

    for (int i = 0; i < 256; i++) begin mem_m[i] = 32'h0; kn_m[i] = 4'h0; end
    mona_m = 8'h0; mond_m = 32'h0; mondk_m = 4'hF; rdy_m = 1'b0; err_m = 1'b0;

    reset_n = 1'b0; jdo = 38'd0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    address = 8'h0; read = 1'b0; write = 1'b0; writedata = 32'h0;
    byteenable = 4'h0; debugaccess = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    cpu_op(1'b0, 8'hC0, 32'h0, 4'hF, 1'b0, c0_before);

    // Table-driven directed vectors
    for (int i = 0; i < 23; i++) begin
      case (tbl[i].op)
        OP_CWR: cpu_op(1'b1, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].flag, rv);
        OP_CRD: begin
          cpu_op(1'b0, tbl[i].addr, 32'h0, tbl[i].be, 1'b0, rv);
          check($sformatf("vec%0d_readdata", i), rv, tbl[i].exp_d);
        end
        default: begin
          jtag_op(tbl[i].op, tbl[i].addr, tbl[i].flag, tbl[i].data);
          check($sformatf("vec%0d_mona", i), 32'(MonAReg), 32'(tbl[i].exp_a));
          check($sformatf("vec%0d_error", i), 32'(monitor_error), 32'(tbl[i].exp_err));
          if (tbl[i].chk_d) check($sformatf("vec%0d_mond", i), MonDReg, tbl[i].exp_d);
        end
      endcase
    end

    // Protected word C0 survived both the JTAG and the CPU write attempts
    cpu_op(1'b0, 8'hC0, 32'h0, 4'hF, 1'b0, rv);
    check("c0_unchanged", rv, c0_before);

    // Simultaneous: JTAG no-action read vs CPU read in the dispatch cycle
    jtag_op(OP_JSET, 8'h10, 1'b0, 32'h0);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    address = 8'h05; read = 1'b1;
    tick();
    check("sim_wait_m1", 32'(waitrequest), 32'd1);
    tick();
    check("sim_wait_m2", 32'(waitrequest), 32'd1);
    check("sim_jtag_first_mond", MonDReg, 32'hDEADBEEF);
    check("sim_jtag_first_ready", 32'(monitor_ready), 32'd1);
    check("sim_jtag_first_mona", 32'(MonAReg), 32'h11);
    tick();
    check("sim_wait_m3", 32'(waitrequest), 32'd0);
    check("sim_readdata", readdata, 32'h0000CCDD);
    read = 1'b0;
    tick();
    mona_m = 8'h11; mond_m = 32'hDEADBEEF; mondk_m = 4'hF; rdy_m = 1'b1; err_m = 1'b0;

    // Back-to-back strobes: second one dropped
    jtag_op(OP_JSET, 8'h30, 1'b0, 32'h0);
    jdo = 38'd0; jdo[34:3] = 32'h12345678; take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = 38'd0; jdo[33:26] = 8'h50; take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    repeat (3) tick();
    check("b2b_error", 32'(monitor_error), 32'd1);
    check("b2b_ready", 32'(monitor_ready), 32'd1);
    check("b2b_mona", 32'(MonAReg), 32'h31);
    check("b2b_mond", MonDReg, 32'h12345678);
    mem_m[8'h30] = 32'h12345678; kn_m[8'h30] = 4'hF;
    mona_m = 8'h31; mond_m = 32'h12345678; rdy_m = 1'b1; err_m = 1'b1;
    cpu_op(1'b0, 8'h30, 32'h0, 4'hF, 1'b0, rv);
    check("b2b_ram", rv, 32'h12345678);

    // Reset while in J_READ
    jdo = 38'd0; jdo[33:26] = 8'h10; jdo[25] = 1'b1; take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    check("midreset_cmd_lost", 32'(monitor_ready), 32'd0);
    mona_m = 8'h0; mond_m = 32'h0; mondk_m = 4'hF; rdy_m = 1'b0; err_m = 1'b0;
    cpu_op(1'b0, 8'h10, 32'h0, 4'hF, 1'b0, rv);
    check("midreset_ram_kept", rv, 32'hDEADBEEF);

    // Fill the writable region, then randomized traffic against the model
    for (int a = 0; a < 192; a++) cpu_op(1'b1, 8'(a), $urandom, 4'hF, 1'b1, rv);
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 3);
      ra = (sel == 1) ? 8'(8'hBC + $urandom_range(0, 6)) :
           (sel == 2) ? 8'(8'hFD + $urandom_range(0, 2)) : 8'($urandom);
      case ($urandom_range(0, 4))
        0: cpu_op(1'b1, ra, $urandom, 4'($urandom), 1'($urandom_range(0, 3) != 0), rv);
        1: begin
          cpu_op(1'b0, ra, 32'h0, 4'hF, 1'b0, rv);
          check("rand_readdata", rv & bmask(kn_m[ra]), mem_m[ra] & bmask(kn_m[ra]));
        end
        2: jtag_op(OP_JSET, ra, 1'($urandom), 32'h0);
        3: jtag_op(OP_JNOACT, 8'h0, 1'b0, 32'h0);
        default: jtag_op(OP_JWR, 8'h0, 1'b0, $urandom);
      endcase
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
